// File: rtl/serial_magnitude_comp_if.sv
// Start/done bundle for serial_magnitude_comp: operands and mode in, busy/done and lt/eq/gt out.
// Handshake: a request is taken on any rising edge where start=1 and the comparator is idle
// or finishing (not busy); done is a one-cycle pulse and lt/eq/gt hold until the next accept.
interface serial_magnitude_comp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [1:0]       state_dbg;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, lt, eq, gt, state_dbg
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, lt, eq, gt, state_dbg
  );
endinterface

// File: rtl/serial_magnitude_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed/unsigned mode.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN finishes on the first differing slice.
module serial_magnitude_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 rst,
  serial_magnitude_comp_if.slave cmp
);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_magnitude_comp: WIDTH must be >= 1 and a multiple of DIGIT in 1..WIDTH");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             dec_lt;
  logic             busy_q;
  logic             done_q;
  logic             lt_q;
  logic             eq_q;
  logic             gt_q;

  // Operands shift left each step, so the live slice is always the top DIGIT bits.
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic             differs;
  logic             slice_lt;
  logic             last;
  logic             finish;

  assign slice_a  = a_q[WIDTH-1 -: DIGIT];
  assign slice_b  = b_q[WIDTH-1 -: DIGIT];
  assign differs  = (slice_a != slice_b);
  assign slice_lt = (slice_a < slice_b);
  assign last     = (idx == IW'(N - 1));

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  assign finish = last || (differs && !decided);
`else
  assign finish = last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (cmp.start) begin
            // Flipping both MSBs maps two's complement onto offset binary.
            state   <= S_RUN;
            a_q     <= cmp.a ^ (cmp.signed_mode ? MSB_MASK : '0);
            b_q     <= cmp.b ^ (cmp.signed_mode ? MSB_MASK : '0);
            idx     <= '0;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            busy_q  <= 1'b1;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q <= a_q << DIGIT;
          b_q <= b_q << DIGIT;
          idx <= idx + IW'(1);
          if (differs && !decided) begin
            decided <= 1'b1;
            dec_lt  <= slice_lt;
          end
          if (finish) begin
            state  <= S_DONE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (decided) begin
              lt_q <= dec_lt;
              gt_q <= !dec_lt;
            end else if (differs) begin
              lt_q <= slice_lt;
              gt_q <= !slice_lt;
            end else begin
              eq_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmp.busy      = busy_q;
  assign cmp.done      = done_q;
  assign cmp.lt        = lt_q;
  assign cmp.eq        = eq_q;
  assign cmp.gt        = gt_q;
  assign cmp.state_dbg = state;

endmodule

// File: tb/tb_serial_magnitude_comp.sv
// Bench for serial_magnitude_comp: five instances (8/1, 16/4, 12/1, 12/3, 12/12) checked
// against an arithmetic reference compare and an expected-latency model.
module tb_serial_magnitude_comp;

  function automatic int w_of(int g);
    case (g)
      0: return 8;
      1: return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int d_of(int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 3;
      default: return 12;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        start_v [5];
  logic [31:0] a_v     [5];
  logic [31:0] b_v     [5];
  logic        mode_v  [5];
  logic [4:0]  busy_v, done_v, lt_v, eq_v, gt_v;
  logic [1:0]  state_v [5];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    serial_magnitude_comp_if #(.WIDTH(W)) bus ();
    serial_magnitude_comp #(.WIDTH(W), .DIGIT(D)) dut (
      .clk (clk),
      .rst (rst),
      .cmp (bus)
    );
    assign bus.start       = start_v[g];
    assign bus.a           = a_v[g][W-1:0];
    assign bus.b           = b_v[g][W-1:0];
    assign bus.signed_mode = mode_v[g];
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;
    assign lt_v[g]         = bus.lt;
    assign eq_v[g]         = bus.eq;
    assign gt_v[g]         = bus.gt;
    assign state_v[g]      = bus.state_dbg;
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  function automatic logic [31:0] mask_of(int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [2:0] ref_cmp(int w, logic [31:0] a, logic [31:0] b, logic mode);
    longint va, vb;
    logic [31:0] ma, mb;
    ma = a & mask_of(w);
    mb = b & mask_of(w);
    va = longint'(ma);
    vb = longint'(mb);
    if (mode && ma[w-1]) va = va - (longint'(1) << w);
    if (mode && mb[w-1]) vb = vb - (longint'(1) << w);
    return {va < vb, va == vb, va > vb};
  endfunction

  function automatic int exp_lat(int g, logic [31:0] a, logic [31:0] b);
    int w, d;
    logic [31:0] x;
    w = w_of(g);
    d = d_of(g);
    x = (a ^ b) & mask_of(w);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    for (int i = w - 1; i >= 0; i--) begin
      if (x[i]) return (w - 1 - i) / d + 1;
    end
`else
    if (x == 32'd0) return w / d;
`endif
    return w / d;
  endfunction

  // driver: one full compare on instance g, operands scrambled after accept
  task automatic run_cmp(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic mode, output logic [2:0] res, output int lat,
                         output int busy_cnt, output logic both, output logic done_after);
    int c;
    @(negedge clk);
    a_v[g] = a;
    b_v[g] = b;
    mode_v[g] = mode;
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    a_v[g] = $urandom;
    b_v[g] = $urandom;
    mode_v[g] = ~mode;
    c = 0;
    busy_cnt = 0;
    while (!done_v[g] && c < 200) begin
      if (busy_v[g]) busy_cnt++;
      @(negedge clk);
      c++;
    end
    lat = c;
    both = busy_v[g] & done_v[g];
    res = {lt_v[g], eq_v[g], gt_v[g]};
    @(negedge clk);
    done_after = done_v[g];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int g = 0; g < 5; g++) begin
      start_v[g] = 1'b0;
      a_v[g] = '0;
      b_v[g] = '0;
      mode_v[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      n_cmp++;
      if ({busy_v[g], done_v[g], lt_v[g], eq_v[g], gt_v[g]} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got busy/done/lt/eq/gt=%b expected 00000", g,
                 {busy_v[g], done_v[g], lt_v[g], eq_v[g], gt_v[g]});
      end
      n_cmp++;
      if (state_v[g] !== 2'd0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %0d expected 0", g, state_v[g]);
      end
    end
  endtask

  task automatic test_directed(input string name, input int g, input logic [31:0] a,
                               input logic [31:0] b, input logic mode, input logic [2:0] want);
    logic [2:0] res;
    int lat, busy_cnt, want_lat;
    logic both, done_after;
    want_lat = exp_lat(g, a, b);
    run_cmp(g, a, b, mode, res, lat, busy_cnt, both, done_after);
    n_cmp++;
    if (res !== want) begin
      n_err++;
      $display("FAIL %s_result: got lt/eq/gt=%b expected %b", name, res, want);
    end
    n_cmp++;
    if (lat !== want_lat) begin
      n_err++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, want_lat);
    end
    n_cmp++;
    if (busy_cnt !== want_lat) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, want_lat);
    end
    n_cmp++;
    if ({both, done_after} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_done_pulse: got both/done_next=%b expected 00", name, {both, done_after});
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    a_v[0] = 32'h01;
    b_v[0] = 32'h00;
    mode_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_busy_before: got %b expected 1", busy_v[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy_v[0], done_v[0], lt_v[0], eq_v[0], gt_v[0], state_v[0]} !== 7'b0) begin
      n_err++;
      $display("FAIL abort_cleared: got busy/done/lt/eq/gt/state=%b expected 0000000",
               {busy_v[0], done_v[0], lt_v[0], eq_v[0], gt_v[0], state_v[0]});
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
    end
    test_directed("after_abort", 0, 32'd3, 32'd2, 1'b0, 3'b001);
  endtask

  task automatic test_start_ignored;
    int c, want_lat;
    want_lat = exp_lat(0, 32'h10, 32'h20);
    @(negedge clk);
    a_v[0] = 32'h10;
    b_v[0] = 32'h20;
    mode_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    a_v[0] = 32'hFF;
    b_v[0] = 32'h00;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    c = 2;
    while (!done_v[0] && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if ({lt_v[0], eq_v[0], gt_v[0]} !== 3'b100) begin
      n_err++;
      $display("FAIL midrun_result: got lt/eq/gt=%b expected 100", {lt_v[0], eq_v[0], gt_v[0]});
    end
    n_cmp++;
    if (c !== want_lat) begin
      n_err++;
      $display("FAIL midrun_latency: got %0d expected %0d", c, want_lat);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy_v[0], done_v[0], state_v[0]} !== 4'b0) begin
      n_err++;
      $display("FAIL midrun_not_queued: got busy/done/state=%b expected 0000",
               {busy_v[0], done_v[0], state_v[0]});
    end
  endtask

  task automatic test_back_to_back;
    int c, d1, d2;
    logic [2:0] r1, r2;
    d1 = -1;
    d2 = -1;
    r1 = 3'b0;
    r2 = 3'b0;
    @(negedge clk);
    a_v[0] = 32'h5A;
    b_v[0] = 32'h5A;
    mode_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    a_v[0] = 32'd3;
    b_v[0] = 32'd2;
    c = 0;
    while (d2 < 0 && c < 100) begin
      @(negedge clk);
      c++;
      if (d1 >= 0 && c == d1 + 1) begin
        n_cmp++;
        if ({busy_v[0], lt_v[0], eq_v[0], gt_v[0]} !== 4'b1000) begin
          n_err++;
          $display("FAIL b2b_reaccept: got busy/lt/eq/gt=%b expected 1000",
                   {busy_v[0], lt_v[0], eq_v[0], gt_v[0]});
        end
      end
      if (done_v[0]) begin
        if (d1 < 0) begin
          d1 = c;
          r1 = {lt_v[0], eq_v[0], gt_v[0]};
        end else begin
          d2 = c;
          r2 = {lt_v[0], eq_v[0], gt_v[0]};
          start_v[0] = 1'b0;
        end
      end
    end
    start_v[0] = 1'b0;
    n_cmp++;
    if (d1 !== exp_lat(0, 32'h5A, 32'h5A) || r1 !== 3'b010) begin
      n_err++;
      $display("FAIL b2b_first: got done at %0d res %b expected %0d res 010",
               d1, r1, exp_lat(0, 32'h5A, 32'h5A));
    end
    n_cmp++;
    if (d2 - d1 !== exp_lat(0, 32'd3, 32'd2) + 1 || r2 !== 3'b001) begin
      n_err++;
      $display("FAIL b2b_second: got gap %0d res %b expected gap %0d res 001",
               d2 - d1, r2, exp_lat(0, 32'd3, 32'd2) + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_sweep;
    logic [2:0] res, want;
    logic [31:0] a, b, m;
    int lat, busy_cnt, want_lat, sel;
    logic both, done_after, mode;
    for (int g = 2; g < 5; g++) begin
      m = mask_of(w_of(g));
      for (int i = 0; i < 40; i++) begin
        mode = i[0];
        a = $urandom & m;
        sel = $urandom_range(0, 7);
        if (sel == 0) b = a;
        else if (sel == 1) b = a ^ (32'd1 << $urandom_range(0, w_of(g) - 1));
        else b = $urandom & m;
        want = ref_cmp(w_of(g), a, b, mode);
        want_lat = exp_lat(g, a, b);
        run_cmp(g, a, b, mode, res, lat, busy_cnt, both, done_after);
        n_cmp++;
        if (res !== want || !$onehot(res)) begin
          n_err++;
          $display("FAIL sweep_result[g%0d a=%h b=%h s=%b]: got %b expected %b",
                   g, a, b, mode, res, want);
        end
        n_cmp++;
        if (lat !== want_lat || busy_cnt !== want_lat) begin
          n_err++;
          $display("FAIL sweep_latency[g%0d a=%h b=%h]: got lat %0d busy %0d expected %0d",
                   g, a, b, lat, busy_cnt, want_lat);
        end
        n_cmp++;
        if ({both, done_after} !== 2'b00) begin
          n_err++;
          $display("FAIL sweep_done_pulse[g%0d]: got both/done_next=%b expected 00",
                   g, {both, done_after});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("equal_5a", 0, 32'h5A, 32'h5A, 1'b0, 3'b010);
    test_directed("signed_ff_01", 0, 32'hFF, 32'h01, 1'b1, 3'b100);
    test_directed("unsigned_ff_01", 0, 32'hFF, 32'h01, 1'b0, 3'b001);
    test_directed("digit4_1234", 1, 32'h1234, 32'h1334, 1'b0, 3'b100);
    test_directed("signed_min_max", 1, 32'h8000, 32'h7FFF, 1'b1, 3'b100);
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
